// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions used by the register slaves and the on-chip self-test master.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WB   = 3'd2,
        ST_RA   = 3'd3,
        ST_RD   = 3'd4,
        ST_NEXT = 3'd5,
        ST_FIN  = 3'd6
    } selftest_state_t;

    function automatic logic resp_is_okay(input logic [1:0] resp);
        return (resp == RESP_OKAY);
    endfunction

endpackage

// File: rtl/axi_lite_selftest_pattern_gen.sv
// Word index plus incrementally stepped address/pattern for the self-test master.
module axi_lite_selftest_pattern_gen
    import axi_lite_pkg::*;
#(
    parameter int                      C_ADDR_WIDTH  = 32,
    parameter int                      C_DATA_WIDTH  = 32,
    parameter int                      C_NUM_WORDS   = 4,
    parameter int                      C_ADDR_STRIDE = 4,
    parameter logic [C_DATA_WIDTH-1:0] C_PATTERN_INC = 32'h9E3779B9
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    load_i,
    input  logic                    step_i,
    input  logic                    restart_i,
    input  logic [C_ADDR_WIDTH-1:0] base_i,
    input  logic [C_DATA_WIDTH-1:0] seed_i,
    output logic [C_ADDR_WIDTH-1:0] addr_o,
    output logic [C_DATA_WIDTH-1:0] data_o,
    output logic                    last_o
);

    localparam int IW = (C_NUM_WORDS > 1) ? $clog2(C_NUM_WORDS) : 1;

    logic [IW-1:0]           idx_q,  idx_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_DATA_WIDTH-1:0] data_q, data_d;
    logic [C_ADDR_WIDTH-1:0] base_q, base_d;
    logic [C_DATA_WIDTH-1:0] seed_q, seed_d;

    // Next index/address/pattern: load from ports, rewind to the stored origin, or step by one word.
    always_comb begin
        idx_d  = idx_q;
        addr_d = addr_q;
        data_d = data_q;
        base_d = base_q;
        seed_d = seed_q;
        if (load_i) begin
            base_d = base_i;
            seed_d = seed_i;
            idx_d  = '0;
            addr_d = base_i;
            data_d = seed_i;
        end else if (restart_i) begin
            idx_d  = '0;
            addr_d = base_q;
            data_d = seed_q;
        end else if (step_i) begin
            idx_d  = idx_q + IW'(1);
            addr_d = addr_q + C_ADDR_WIDTH'(C_ADDR_STRIDE);
            data_d = data_q + C_PATTERN_INC;
        end else begin
            idx_d  = idx_q;
        end
    end

    // Generator state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            base_q <= '0;
            seed_q <= '0;
        end else begin
            idx_q  <= idx_d;
            addr_q <= addr_d;
            data_q <= data_d;
            base_q <= base_d;
            seed_q <= seed_d;
        end
    end

    assign addr_o = addr_q;
    assign data_o = data_q;
    assign last_o = (idx_q == IW'(C_NUM_WORDS - 1));

endmodule

// File: rtl/axi_lite_reg_selftest_master.sv
// AXI4-Lite master that writes a generated pattern to a register slave, reads it back and
// reports response/data errors, first-error details and handshake timeouts.
module axi_lite_reg_selftest_master
    import axi_lite_pkg::*;
#(
    parameter int                      C_ADDR_WIDTH     = 32,
    parameter int                      C_DATA_WIDTH     = 32,
    parameter int                      C_NUM_WORDS      = 4,
    parameter int                      C_ADDR_STRIDE    = 4,
    parameter logic [C_DATA_WIDTH-1:0] C_PATTERN_INC    = 32'h9E3779B9,
    parameter int                      C_TIMEOUT_CYCLES = 1023,
    parameter int                      C_ERR_CNT_W      = 8
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic                        start,
    input  logic                        mode,
    input  logic [C_ADDR_WIDTH-1:0]     base_addr,
    input  logic [C_DATA_WIDTH-1:0]     seed,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        timeout,
    output logic [C_ERR_CNT_W-1:0]      err_count,
    output logic [C_ADDR_WIDTH-1:0]     first_err_addr,
    output logic [C_DATA_WIDTH-1:0]     first_err_data,
    output logic [C_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                  m_axi_awprot,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [C_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [C_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                  m_axi_arprot,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [C_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);

    localparam int TCW = $clog2(C_TIMEOUT_CYCLES + 1);

    selftest_state_t state_q, state_d;
    logic mode_q, mode_d;
    logic rd_phase_q, rd_phase_d;
    logic awvalid_q, awvalid_d;
    logic wvalid_q, wvalid_d;
    logic bready_q, bready_d;
    logic arvalid_q, arvalid_d;
    logic rready_q, rready_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;

    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic                    timeout_q, timeout_d;
    logic [C_ERR_CNT_W-1:0]  err_count_q, err_count_d;
    logic [C_ADDR_WIDTH-1:0] fea_q, fea_d;
    logic [C_DATA_WIDTH-1:0] fed_q, fed_d;

    logic                    start_acc_s;
    logic                    gen_load_s, gen_step_s, gen_restart_s, gen_last_s;
    logic [C_ADDR_WIDTH-1:0] gen_addr_s;
    logic [C_DATA_WIDTH-1:0] gen_data_s;
    logic [1:0]              err_inc_s;
    logic [C_DATA_WIDTH-1:0] err_data_s;
    logic                    fin_s;
    logic                    wait_s;
    logic                    to_hit_s;
    logic [C_ERR_CNT_W:0]    err_sum_s;

    // busy is low only in IDLE and FIN, so a start is never taken mid-run.
    assign start_acc_s = start && !busy_q;

    axi_lite_selftest_pattern_gen #(
        .C_ADDR_WIDTH (C_ADDR_WIDTH),
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_NUM_WORDS  (C_NUM_WORDS),
        .C_ADDR_STRIDE(C_ADDR_STRIDE),
        .C_PATTERN_INC(C_PATTERN_INC)
    ) u_gen (
        .clk_i    (ACLK),
        .rst_ni   (ARESETN),
        .load_i   (gen_load_s),
        .step_i   (gen_step_s),
        .restart_i(gen_restart_s),
        .base_i   (base_addr),
        .seed_i   (seed),
        .addr_o   (gen_addr_s),
        .data_o   (gen_data_s),
        .last_o   (gen_last_s)
    );

    // Sequencer: next state, channel VALID/READY levels, generator control and per-beat error count.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        rd_phase_d    = rd_phase_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        gen_load_s    = 1'b0;
        gen_step_s    = 1'b0;
        gen_restart_s = 1'b0;
        err_inc_s     = 2'd0;
        err_data_s    = '0;
        fin_s         = 1'b0;
        case (state_q)
            ST_WR: begin
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (wvalid_q && m_axi_wready) begin
                    wvalid_d = 1'b0;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_WB;
                    bready_d = 1'b1;
                end else begin
                    state_d  = ST_WR;
                end
            end
            ST_WB: begin
                if (m_axi_bvalid) begin
                    bready_d  = 1'b0;
                    err_inc_s = resp_is_okay(m_axi_bresp) ? 2'd0 : 2'd1;
                    if (mode_q) begin
                        state_d = ST_NEXT;
                    end else begin
                        state_d   = ST_RA;
                        arvalid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_RA: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD;
                end else begin
                    state_d   = ST_RA;
                end
            end
            ST_RD: begin
                if (m_axi_rvalid) begin
                    rready_d   = 1'b0;
                    // A bad response and a data mismatch on one beat are two separate errors.
                    err_inc_s  = {1'b0, !resp_is_okay(m_axi_rresp)} +
                                 {1'b0, (m_axi_rdata != gen_data_s)};
                    err_data_s = m_axi_rdata;
                    state_d    = ST_NEXT;
                end else begin
                    state_d    = ST_RD;
                end
            end
            ST_NEXT: begin
                if (gen_last_s) begin
                    if (mode_q && !rd_phase_q) begin
                        gen_restart_s = 1'b1;
                        rd_phase_d    = 1'b1;
                        arvalid_d     = 1'b1;
                        state_d       = ST_RA;
                    end else begin
                        fin_s   = 1'b1;
                        state_d = ST_FIN;
                    end
                end else begin
                    gen_step_s = 1'b1;
                    if (mode_q && rd_phase_q) begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RA;
                    end else begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (start_acc_s) begin
            state_d    = ST_WR;
            mode_d     = mode;
            rd_phase_d = 1'b0;
            awvalid_d  = 1'b1;
            wvalid_d   = 1'b1;
            gen_load_s = 1'b1;
        end else begin
            mode_d     = mode_q;
        end
    end

    // Per-handshake wait counter: restarts whenever the FSM changes state, saturates at the limit.
    always_comb begin
        wait_s = ((state_q == ST_WR) || (state_q == ST_WB) ||
                  (state_q == ST_RA) || (state_q == ST_RD)) && (state_d == state_q);
        if (wait_s) begin
            tcnt_d = (tcnt_q == TCW'(C_TIMEOUT_CYCLES)) ? tcnt_q : tcnt_q + TCW'(1);
        end else begin
            tcnt_d = '0;
        end
        to_hit_s = wait_s && (tcnt_q == TCW'(C_TIMEOUT_CYCLES - 1));
    end

    // Status next-state: run flags, saturating error count and first-error capture.
    always_comb begin
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        err_count_d = err_count_q;
        fea_d       = fea_q;
        fed_d       = fed_q;
        err_sum_s   = {1'b0, err_count_q} + (C_ERR_CNT_W + 1)'(err_inc_s);
        if (start_acc_s) begin
            busy_d      = 1'b1;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            timeout_d   = 1'b0;
            err_count_d = '0;
            fea_d       = '0;
            fed_d       = '0;
        end else begin
            if (err_inc_s != 2'd0) begin
                err_count_d = err_sum_s[C_ERR_CNT_W] ? '1 : err_sum_s[C_ERR_CNT_W-1:0];
                if (err_count_q == '0) begin
                    fea_d = gen_addr_s;
                    fed_d = err_data_s;
                end else begin
                    fea_d = fea_q;
                end
            end else begin
                err_count_d = err_count_q;
            end
            if (to_hit_s) begin
                timeout_d = 1'b1;
                done_d    = 1'b1;
                pass_d    = 1'b0;
            end else begin
                timeout_d = timeout_q;
            end
            if (fin_s) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                pass_d = (err_count_q == '0) && !timeout_q;
            end else begin
                busy_d = busy_q;
            end
        end
    end

    // All sequencer and status registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            rd_phase_q  <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            tcnt_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_count_q <= '0;
            fea_q       <= '0;
            fed_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            rd_phase_q  <= rd_phase_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            tcnt_q      <= tcnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            err_count_q <= err_count_d;
            fea_q       <= fea_d;
            fed_q       <= fed_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_count_q;
    assign first_err_addr = fea_q;
    assign first_err_data = fed_q;

    assign m_axi_awaddr  = gen_addr_s;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = gen_data_s;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = gen_addr_s;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_reg_selftest_master.sv
// Bench: behavioural AXI4-Lite RAM slave with random ready delays and fault injection,
// checked against a transaction-level model of the self-test run.
module tb_axi_lite_reg_selftest_master;

    localparam int          NW     = 4;
    localparam int          STRIDE = 4;
    localparam logic [31:0] INC    = 32'h9E3779B9;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic [31:0] base_addr = 32'h0;
    logic [31:0] seed = 32'h0;
    logic busy, done, pass, timeout;
    logic [7:0] err_count;
    logic [31:0] first_err_addr, first_err_data;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
    logic [31:0] m_axi_rdata = 32'h0;
    logic [2:0] m_axi_awprot, m_axi_arprot;
    logic [3:0] m_axi_wstrb;
    logic m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
    logic m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
    logic [1:0] m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;

    int total = 0;
    int bad = 0;

    // slave configuration and state
    int aw_fix = -1, w_fix = -1, aw_block = 0;
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    bit b_fire = 1'b0, r_fire = 1'b0;
    bit stuck_en = 1'b0, slverr_en = 1'b0, decerr_en = 1'b0;
    logic [31:0] stuck_addr = 32'h0, slverr_addr = 32'h0, decerr_addr = 32'h0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] awq[$], wq[$], arq[$];
    logic [32:0] txn_log[$];
    logic [31:0] wdata_log[$];

    axi_lite_reg_selftest_master dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .mode(mode),
        .base_addr(base_addr), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int fix);
        return (fix >= 0) ? fix : int'($urandom_range(5, 0));
    endfunction

    // Slave: everything is decided at the falling edge; a VALID&READY seen here completes at the next rise.
    initial begin : slave
        logic [31:0] a, d;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
                m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
                awq.delete(); wq.delete(); arq.delete();
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                b_fire = 1'b0; r_fire = 1'b0;
            end else begin
                if (b_fire) begin m_axi_bvalid = 1'b0; b_fire = 1'b0; end
                if (!m_axi_bvalid && awq.size() > 0 && wq.size() > 0) begin
                    if (b_cnt >= b_dly) begin
                        a = awq.pop_front();
                        d = wq.pop_front();
                        if (stuck_en && a == stuck_addr) d[0] = 1'b0;
                        mem[a] = d;
                        m_axi_bresp = (slverr_en && a == slverr_addr) ? 2'b10 : 2'b00;
                        m_axi_bvalid = 1'b1;
                        b_cnt = 0; b_dly = pick(-1);
                    end else b_cnt++;
                end
                if (m_axi_bvalid && m_axi_bready) b_fire = 1'b1;

                if (r_fire) begin m_axi_rvalid = 1'b0; r_fire = 1'b0; end
                if (!m_axi_rvalid && arq.size() > 0) begin
                    if (r_cnt >= r_dly) begin
                        a = arq.pop_front();
                        d = mem.exists(a) ? mem[a] : 32'h0;
                        m_axi_rresp = 2'b00;
                        if (decerr_en && a == decerr_addr) begin m_axi_rresp = 2'b11; d[0] = ~d[0]; end
                        m_axi_rdata = d;
                        m_axi_rvalid = 1'b1;
                        r_cnt = 0; r_dly = pick(-1);
                    end else r_cnt++;
                end
                if (m_axi_rvalid && m_axi_rready) r_fire = 1'b1;

                if (aw_block > 0) begin aw_block--; m_axi_awready = 1'b0; end
                else if (m_axi_awvalid && aw_cnt >= aw_dly) m_axi_awready = 1'b1;
                else begin m_axi_awready = 1'b0; if (m_axi_awvalid) aw_cnt++; end
                if (m_axi_awvalid && m_axi_awready) begin
                    awq.push_back(m_axi_awaddr); txn_log.push_back({1'b0, m_axi_awaddr});
                    aw_cnt = 0; aw_dly = pick(aw_fix);
                end

                if (m_axi_wvalid && w_cnt >= w_dly) m_axi_wready = 1'b1;
                else begin m_axi_wready = 1'b0; if (m_axi_wvalid) w_cnt++; end
                if (m_axi_wvalid && m_axi_wready) begin
                    wq.push_back(m_axi_wdata); wdata_log.push_back(m_axi_wdata);
                    w_cnt = 0; w_dly = pick(w_fix);
                end

                if (m_axi_arvalid && ar_cnt >= ar_dly) m_axi_arready = 1'b1;
                else begin m_axi_arready = 1'b0; if (m_axi_arvalid) ar_cnt++; end
                if (m_axi_arvalid && m_axi_arready) begin
                    arq.push_back(m_axi_araddr); txn_log.push_back({1'b1, m_axi_araddr});
                    ar_cnt = 0; ar_dly = pick(-1);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".pass"}, pass, 0);
        check({tag, ".timeout"}, timeout, 0);
        check({tag, ".err"}, err_count, 0);
        check({tag, ".fea"}, first_err_addr, 0);
        check({tag, ".fed"}, first_err_data, 0);
        check({tag, ".valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
        check({tag, ".readys"}, {m_axi_bready, m_axi_rready}, 0);
    endtask

    // One run: build the expected transaction list and result from the test rules, run, compare.
    task automatic run_case(input string tag, input logic md, input logic [31:0] sd,
                            input logic [31:0] ba, input bit exp_to, input bit poke);
        logic [31:0] addr_m [NW];
        logic [31:0] data_m [NW];
        logic [32:0] exp_txn [$];
        logic [31:0] fea_m, fed_m, rd;
        int err_m, inc, i, c;
        bit is_rd, first_seen, finished;
        for (int k = 0; k < NW; k++) begin
            addr_m[k] = ba + 32'(k * STRIDE);
            data_m[k] = sd + INC * 32'(k);
        end
        for (int k = 0; k < NW; k++) begin
            if (md == 1'b0) begin
                exp_txn.push_back({1'b0, addr_m[k]});
                exp_txn.push_back({1'b1, addr_m[k]});
            end else exp_txn.push_back({1'b0, addr_m[k]});
        end
        if (md == 1'b1) for (int k = 0; k < NW; k++) exp_txn.push_back({1'b1, addr_m[k]});
        err_m = 0; first_seen = 1'b0; fea_m = 32'h0; fed_m = 32'h0;
        for (int k = 0; k < 2 * NW; k++) begin
            i = md ? (k % NW) : (k / 2);
            is_rd = md ? (k >= NW) : (k % 2 == 1);
            inc = 0; rd = 32'h0;
            if (!is_rd) begin
                if (slverr_en && addr_m[i] == slverr_addr) inc = 1;
            end else begin
                rd = data_m[i];
                if (stuck_en && addr_m[i] == stuck_addr) rd[0] = 1'b0;
                if (decerr_en && addr_m[i] == decerr_addr) begin rd[0] = ~rd[0]; inc = 1; end
                if (rd != data_m[i]) inc = inc + 1;
            end
            if (inc > 0 && !first_seen) begin first_seen = 1'b1; fea_m = addr_m[i]; fed_m = rd; end
            err_m = err_m + inc;
        end
        if (err_m > 255) err_m = 255;

        txn_log.delete(); wdata_log.delete();
        @(negedge ACLK);
        mode = md; seed = sd; base_addr = ba; start = 1'b1;
        @(negedge ACLK);
        start = 1'b0; mode = ~md; seed = ~sd; base_addr = ~ba;
        check({tag, ".busy_up"}, busy, 1);
        check({tag, ".done_clr"}, done, 0);
        finished = 1'b0;
        for (c = 1; c <= 30000 && !finished; c++) begin
            @(negedge ACLK);
            start = (poke && c == 3) ? 1'b1 : 1'b0;
            if (exp_to && c == 1000) check({tag, ".to_early"}, timeout, 0);
            if (exp_to && c == 1040) begin
                check({tag, ".to_set"}, timeout, 1);
                check({tag, ".to_done"}, done, 1);
                check({tag, ".to_busy"}, busy, 1);
                check({tag, ".to_awvalid"}, m_axi_awvalid, 1);
            end
            if (done && !busy) finished = 1'b1;
        end
        start = 1'b0;
        check({tag, ".finished"}, finished, 1);
        check({tag, ".done"}, done, 1);
        check({tag, ".pass"}, pass, (err_m == 0 && !exp_to) ? 1 : 0);
        check({tag, ".timeout"}, timeout, exp_to ? 1 : 0);
        check({tag, ".err"}, err_count, err_m);
        check({tag, ".fea"}, first_err_addr, fea_m);
        check({tag, ".fed"}, first_err_data, fed_m);
        check({tag, ".ntxn"}, txn_log.size(), exp_txn.size());
        for (int k = 0; k < exp_txn.size() && k < txn_log.size(); k++)
            check($sformatf("%s.txn%0d", tag, k), txn_log[k], exp_txn[k]);
        check({tag, ".nw"}, wdata_log.size(), NW);
        for (int k = 0; k < NW && k < wdata_log.size(); k++)
            check($sformatf("%s.wd%0d", tag, k), wdata_log[k], data_m[k]);
        check({tag, ".const"}, {m_axi_awprot, m_axi_arprot, m_axi_wstrb}, 10'h00F);
    endtask

    task automatic reset_mid_read(input logic md);
        bit hit;
        hit = 1'b0;
        @(negedge ACLK);
        mode = md; seed = $urandom; base_addr = 32'h1000; start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            @(negedge ACLK);
            if (m_axi_rready) hit = 1'b1;
        end
        check("rst.rd_reached", hit, 1);
        ARESETN = 1'b0;
        #1;
        check_all_zero("rst.mid");
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    initial begin : main
        logic [31:0] rb;
        aw_dly = pick(-1); w_dly = pick(-1); ar_dly = pick(-1);
        repeat (3) @(negedge ACLK);
        check_all_zero("reset");
        ARESETN = 1'b1;

        run_case("t1", 1'b0, 32'h0101FFFF, 32'h43C00000, 1'b0, 1'b0);
        run_case("t2", 1'b1, 32'h0101FFFF, 32'h43C00000, 1'b0, 1'b0);

        stuck_en = 1'b1; stuck_addr = 32'h43C00008;
        run_case("t3", 1'b0, 32'hdead0011, 32'h43C00000, 1'b0, 1'b0);
        stuck_en = 1'b0;

        slverr_en = 1'b1; slverr_addr = 32'h43C00004;
        decerr_en = 1'b1; decerr_addr = 32'h43C0000C;
        run_case("t4", 1'b0, $urandom, 32'h43C00000, 1'b0, 1'b0);
        run_case("t4b", 1'b1, $urandom, 32'h43C00000, 1'b0, 1'b0);
        slverr_en = 1'b0; decerr_en = 1'b0;

        aw_block = 2000;
        run_case("t5", 1'b0, $urandom, 32'h43C00000, 1'b1, 1'b0);

        aw_fix = 3; w_fix = 0; aw_dly = 3; w_dly = 0;
        run_case("t6aw", 1'b0, $urandom, 32'h43C00000, 1'b0, 1'b1);
        aw_fix = 0; w_fix = 3; aw_dly = 0; w_dly = 3;
        run_case("t6w", 1'b1, $urandom, 32'h43C00000, 1'b0, 1'b1);
        aw_fix = 2; w_fix = 2; aw_dly = 2; w_dly = 2;
        run_case("t6same", 1'b0, $urandom, 32'h43C00000, 1'b0, 1'b0);
        aw_fix = -1; w_fix = -1;

        reset_mid_read(1'b0);
        run_case("t6post", 1'b1, $urandom, 32'h43C00000, 1'b0, 1'b0);

        run_case("wrap", 1'b0, $urandom, 32'hFFFFFFF8, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            rb = $urandom;
            run_case($sformatf("rnd%0d", n), 1'($urandom_range(1, 0)), $urandom,
                     {rb[31:2], 2'b00}, 1'b0, 1'($urandom_range(1, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
